// File: rtl/usb4_tc_noc_fifo_ctrl_8_35.sv
// Valid/ready FIFO controller for an external 8x35 two-port RAM (sync write, async read)
// with a registered output stage, giving 9 words of total capacity.
module usb4_tc_noc_fifo_ctrl_8_35 #(
  parameter int DEPTH        = 8,
  parameter int WIDTH        = 35,
  parameter int AW           = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             ram_wen,
  output logic [AW-1:0]    ram_waddr,
  output logic [WIDTH-1:0] ram_wdata,
  output logic             ram_ren,
  output logic [AW-1:0]    ram_raddr,
  input  logic [WIDTH-1:0] ram_rdata,
  output logic [AW:0]      count,
  output logic             almost_full,
  output logic [AW:0]      watermark
);

  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] LP_AFULL = (AW+1)'(AFULL_THRESH);

  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_ram_cnt;
  logic             r_ovld;
  logic [WIDTH-1:0] r_oreg;
  logic [AW:0]      r_wm;

  logic             w_push;
  logic             w_pop;
  logic             w_load;
  logic             w_bypass;
  logic             w_ram_empty;
  logic [AW:0]      w_count;

  always_comb begin
    w_ram_empty = (r_ram_cnt == '0);
    // Holding in_ready low during reset guarantees an in-flight word never reaches the RAM.
    in_ready    = !rst && (r_ram_cnt != LP_DEPTH) && !flush;
    out_valid   = r_ovld && !flush;
    w_push      = in_valid && in_ready;
    w_pop       = out_valid && out_ready;
    w_load      = (!r_ovld || w_pop) && !flush;
    ram_ren     = w_load && !w_ram_empty;
    w_bypass    = w_load && w_ram_empty && w_push;
    ram_wen     = w_push && !w_bypass;
    w_count     = r_ram_cnt + {{AW{1'b0}}, r_ovld};
  end

  assign ram_waddr   = r_wptr;
  assign ram_wdata   = in_data;
  assign ram_raddr   = r_rptr;
  assign out_data    = r_oreg;
  assign count       = w_count;
  assign almost_full = (w_count >= LP_AFULL);
  assign watermark   = r_wm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_ram_cnt <= '0;
      r_ovld    <= 1'b0;
      r_oreg    <= '0;
      r_wm      <= '0;
    end else if (flush) begin
      // Output register data is left as-is; only its valid flag is dropped.
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_ram_cnt <= '0;
      r_ovld    <= 1'b0;
      r_wm      <= '0;
    end else begin
      if (ram_wen) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (ram_ren) begin
        r_oreg <= ram_rdata;
        r_rptr <= r_rptr + AW'(1);
        r_ovld <= 1'b1;
      end else if (w_bypass) begin
        r_oreg <= in_data;
        r_ovld <= 1'b1;
      end else if (w_load) begin
        r_ovld <= 1'b0;
      end
      r_ram_cnt <= r_ram_cnt + {{AW{1'b0}}, ram_wen} - {{AW{1'b0}}, ram_ren};
      if (w_count > r_wm) begin
        r_wm <= w_count;
      end
    end
  end

  // The RAM has no write-through, so a same-address read/write would return stale data.
  a_no_same_addr: assert property (@(posedge clk) disable iff (rst)
    !(ram_wen && ram_ren && (ram_waddr == ram_raddr)));
  a_cnt_bound: assert property (@(posedge clk) disable iff (rst)
    r_ram_cnt <= LP_DEPTH);
  a_no_blind_push: assert property (@(posedge clk) disable iff (rst)
    ram_wen |-> in_ready);

endmodule

// File: tb/tb_usb4_tc_noc_fifo_ctrl_8_35.sv
// Scoreboard bench for usb4_tc_noc_fifo_ctrl_8_35 with a behavioural model of the external RAM.
module tb_usb4_tc_noc_fifo_ctrl_8_35;

  localparam int WIDTH = 35;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             ram_wen;
  logic [AW-1:0]    ram_waddr;
  logic [WIDTH-1:0] ram_wdata;
  logic             ram_ren;
  logic [AW-1:0]    ram_raddr;
  logic [WIDTH-1:0] ram_rdata;
  logic [AW:0]      count;
  logic             almost_full;
  logic [AW:0]      watermark;

  logic [WIDTH-1:0] mem [8];
  logic [WIDTH-1:0] q [$];
  int               checks = 0;
  int               errors = 0;
  int               pops   = 0;
  int               pushes = 0;
  bit               wen_seen = 1'b0;

  always #5 clk = ~clk;

  usb4_tc_noc_fifo_ctrl_8_35 dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_ren(ram_ren), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .count(count), .almost_full(almost_full), .watermark(watermark)
  );

  // External RAM: synchronous write, asynchronous read, all-ones when not enabled.
  always @(posedge clk) if (ram_wen) mem[ram_waddr] <= ram_wdata;
  assign ram_rdata = ram_ren ? mem[ram_raddr] : {WIDTH{1'b1}};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stimulus side: every accepted word becomes an expected output.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) begin
      q.push_back(in_data);
      pushes++;
    end
    if (ram_wen) wen_seen = 1'b1;
  end

  // Monitor: compare every word the DUT hands to the consumer.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      pops++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected got %0h expected none", out_data);
      end else begin
        logic [WIDTH-1:0] e;
        e = q.pop_front();
        if (out_data !== e) begin
          errors++;
          $display("FAIL out_data got %0h expected %0h", out_data, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input string name, input int budget);
    int n = 0;
    while ((count != 0 || q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    chk({name, "_count"}, 64'(count), 64'd0);
    chk({name, "_queue"}, 64'(q.size()), 64'd0);
  endtask

  initial begin
    int p0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_wen", 64'(ram_wen), 64'd0);
    step();
    rst = 1'b0;
    #1;
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    chk("idle_ren", 64'(ram_ren), 64'd0);
    chk("idle_wm", 64'(watermark), 64'd0);

    // Bypass into the output register from empty
    wen_seen = 1'b0;
    in_valid = 1'b1; in_data = 35'h1_2345_6789; out_ready = 1'b1;
    chk("byp_wen", 64'(ram_wen), 64'd0);
    step();
    in_valid = 1'b0;
    chk("byp_out_valid", 64'(out_valid), 64'd1);
    chk("byp_count1", 64'(count), 64'd1);
    chk("byp_data", 64'(out_data), 64'h1_2345_6789);
    step();
    chk("byp_count0", 64'(count), 64'd0);
    chk("byp_out_valid0", 64'(out_valid), 64'd0);
    chk("byp_wen_seen", 64'(wen_seen), 64'd0);

    // Fill with the consumer stalled
    out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      in_valid = 1'b1; in_data = 35'(i);
      step();
      chk("fill_count", 64'(count), 64'(i));
      chk("fill_afull", 64'(almost_full), 64'(i >= 6));
      chk("fill_in_ready", 64'(in_ready), 64'(i < 9));
    end
    in_data = 35'd10;
    step();
    chk("full_count", 64'(count), 64'd9);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_wm", 64'(watermark), 64'd9);

    // Drain: in_ready rises only the cycle after the first pop
    p0 = pops;
    out_ready = 1'b1;
    #1;
    chk("pop_full_in_ready", 64'(in_ready), 64'd0);
    step();
    chk("after_pop_in_ready", 64'(in_ready), 64'd1);
    chk("after_pop_count", 64'(count), 64'd8);
    step();
    in_valid = 1'b0;
    repeat (8) step();
    chk("drain_count", 64'(count), 64'd0);
    chk("drain_pops", 64'(pops - p0), 64'd10);
    chk("drain_queue", 64'(q.size()), 64'd0);

    // Streaming with random stalls on both sides
    for (int c = 0; c < 50; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_data   = 35'({$urandom(), $urandom()});
      out_ready = ($urandom_range(3) != 0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    wait_empty("stream", 30);
    chk("stream_balance", 64'(pops), 64'(pushes));

    // Flush at count=5
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1; in_data = 35'(32'h100 + i);
      step();
    end
    chk("pre_flush_count", 64'(count), 64'd5);
    flush = 1'b1; in_data = 35'h3ff;
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    q.delete();
    step();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("post_flush_count", 64'(count), 64'd0);
    chk("post_flush_out_valid", 64'(out_valid), 64'd0);
    chk("post_flush_wm", 64'(watermark), 64'd0);
    chk("post_flush_oreg_kept", 64'(out_data), 64'h101);
    in_valid = 1'b1; in_data = 35'h7_0000_00ab;
    chk("flush_byp_wen", 64'(ram_wen), 64'd0);
    step();
    in_valid = 1'b0;
    chk("flush_byp_valid", 64'(out_valid), 64'd1);
    chk("flush_byp_data", 64'(out_data), 64'h7_0000_00ab);
    out_ready = 1'b1;
    wait_empty("flush_drain", 5);

    // Async reset mid-stream at count=4
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = 35'(32'h200 + i);
      step();
    end
    chk("pre_rst_count", 64'(count), 64'd4);
    in_data = 35'h2ff;
    #2;
    rst = 1'b1;
    q.delete();
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_out_data", 64'(out_data), 64'd0);
    chk("arst_wen", 64'(ram_wen), 64'd0);
    chk("arst_wm", 64'(watermark), 64'd0);
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_data = 35'(32'h300 + i);
      step();
    end
    in_valid = 1'b0;
    wait_empty("rst_drain", 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
